// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, functs,
// ALU control encodings, controller states and ALU operation classes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } ctrl_state_t;

  typedef enum logic [1:0] {
    ADD   = 2'd0,
    SUB   = 2'd1,
    FUNCT = 2'd2
  } aluop_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from the operation class and R-type funct.
module alu_decoder
  import mips_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 3
) (
  input  aluop_t               aluop_i,
  input  logic [5:0]           funct_i,
  output logic [ALUCTRL_W-1:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALUCTRL_W'(ALUCTL_ADD);
    case (aluop_i)
      ADD: alucontrol_o = ALUCTRL_W'(ALUCTL_ADD);
      SUB: alucontrol_o = ALUCTRL_W'(ALUCTL_SUB);
      FUNCT: begin
        // Unrecognised functs fall back to add so ALUWB still has a defined result.
        case (funct_i)
          FUNCT_ADD: alucontrol_o = ALUCTRL_W'(ALUCTL_ADD);
          FUNCT_SUB: alucontrol_o = ALUCTRL_W'(ALUCTL_SUB);
          FUNCT_AND: alucontrol_o = ALUCTRL_W'(ALUCTL_AND);
          FUNCT_OR:  alucontrol_o = ALUCTRL_W'(ALUCTL_OR);
          FUNCT_SLT: alucontrol_o = ALUCTRL_W'(ALUCTL_SLT);
          default:   alucontrol_o = ALUCTRL_W'(ALUCTL_ADD);
        endcase
      end
      default: alucontrol_o = ALUCTRL_W'(ALUCTL_ADD);
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath: sequences each
// instruction and drives all datapath enables and mux selects.
module multicycle_controller
  import mips_pkg::*;
#(
  parameter int unsigned STATE_W   = 4,
  parameter int unsigned ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  output logic                 pcen,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic                 iord,
  output logic                 memtoreg,
  output logic                 regdst,
  output logic [1:0]           pcsrc,
  output logic [ALUCTRL_W-1:0] alucontrol
);

  logic [STATE_W-1:0]   state_q;
  ctrl_state_t          state_d;
  aluop_t               aluop;
  logic                 pcwrite;
  logic                 branch;
  logic                 legal;
  logic [ALUCTRL_W-1:0] alucontrol_dec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= STATE_W'(FETCH);
    else       state_q <= STATE_W'(state_d);
  end

  always_comb begin
    state_d  = FETCH;
    aluop    = ADD;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    legal    = 1'b1;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    pcsrc    = 2'b00;
    case (state_q)
      FETCH: begin
        irwrite = 1'b1;
        alusrcb = 2'b01;
        pcwrite = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        // Unknown opcodes retire here as a NOP; PC was already advanced in FETCH.
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEXEC;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_LW)      state_d = MEMRD;
        else if (op == OP_SW) state_d = MEMWR;
        else                  state_d = FETCH;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = FUNCT;
        state_d = ALUWB;
      end
      ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regwrite = 1'b1;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  alu_decoder #(
    .ALUCTRL_W (ALUCTRL_W)
  ) u_alu_decoder (
    .aluop_i      (aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol_dec)
  );

  assign alucontrol = legal ? alucontrol_dec : '0;
  assign pcen       = pcwrite | (branch & zero);

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle MIPS datapath under `top`.
- Sequences each instruction through fetch, decode, execute, memory and writeback using one shared ALU and one unified instruction/data memory.
- Generates every datapath enable and mux select from opcode, funct and the ALU `zero` flag.
- Replaces the single-cycle combinational decoder. The core keeps the same external `memwrite`/`dataadr`/`writedata` behaviour, spread over multiple cycles.

Parameters:
- STATE_W, 4, width of the state register.
- ALUCTRL_W, 3, width of the `alucontrol` bus.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces state to FETCH immediately.
- op  in  6  instruction[31:26] from the instruction register.
- funct  in  6  instruction[5:0] from the instruction register.
- zero  in  1  ALU result == 0.
- pcen  out  1  PC register enable.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  instruction register load.
- regwrite  out  1  register file write.
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memtoreg  out  1  writeback data select: 1 = data register.
- regdst  out  1  destination register select: 1 = rd, 0 = rt.
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alucontrol  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.

Behaviour:
- Moore FSM. All outputs except `pcen` and `alucontrol` are pure functions of state. Only active signals are listed per state; all others are 0.
- `pcen` = pcwrite | (branch & zero), combinational. pcwrite and branch are internal.
- Reset: asynchronous, active-high; state = FETCH while reset is asserted and on release. Outputs therefore take FETCH values: irwrite = 1, pcen = 1, alusrcb = 01, alucontrol = 010, all else 0. The datapath is held in reset concurrently, so these values are harmless.
- Reset mid-instruction: the current instruction is abandoned. No memwrite or regwrite is issued after reset asserts.
- States, encodings and outputs:
  - FETCH (0): iord = 0, irwrite, alusrca = 0, alusrcb = 01, aluop = add, pcsrc = 00, pcwrite. Next: DECODE.
  - DECODE (1): alusrca = 0, alusrcb = 11, aluop = add.
    - Next state by op: lw 100011 or sw 101011 → MEMADR; R-type 000000 → EXECUTE; beq 000100 → BRANCH; addi 001000 → ADDIEXEC; j 000010 → JUMP.
    - Any other op → FETCH. Such an op is treated as a NOP: no writes, and the PC has already advanced.
  - MEMADR (2): alusrca = 1, alusrcb = 10, add. Next: MEMRD if lw, MEMWR if sw.
  - MEMRD (3): iord = 1. Next: MEMWB.
  - MEMWB (4): regwrite, memtoreg = 1, regdst = 0. Next: FETCH.
  - MEMWR (5): iord = 1, memwrite. Next: FETCH.
  - EXECUTE (6): alusrca = 1, alusrcb = 00, aluop = funct. Next: ALUWB.
  - ALUWB (7): regwrite, regdst = 1, memtoreg = 0. Next: FETCH.
  - BRANCH (8): alusrca = 1, alusrcb = 00, aluop = sub, pcsrc = 01, branch. Next: FETCH.
  - ADDIEXEC (9): alusrca = 1, alusrcb = 10, add. Next: ADDIWB.
  - ADDIWB (10): regwrite, regdst = 0, memtoreg = 0. Next: FETCH.
  - JUMP (11): pcsrc = 10, pcwrite. Next: FETCH.
  - Unused encodings 12–15 → FETCH next cycle, with all outputs 0.
- Instruction latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal op 2.
- ALU decode: aluop add → 010; sub → 110.
- Funct decode (aluop = funct):
  - 100000 → 010
  - 100010 → 110
  - 100100 → 000
  - 100101 → 001
  - 101010 → 111
  - Any other funct → 010; ALUWB still writes the result.
- `memwrite` is asserted for exactly one cycle per sw and never in any other state.
- `irwrite` is asserted only in FETCH.

Decomposition:
- Shared package `mips_pkg`:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - ALU control encodings
  - state enum `ctrl_state_t`
  - aluop enum: ADD, SUB, FUNCT
- Sub-module `alu_decoder`: combinational (aluop, funct) → alucontrol.
- The FSM stays in `multicycle_controller`.

Test Plan:
- Hold reset 22 ns, then release → state = FETCH; irwrite = 1, pcen = 1, alusrcb = 01, alucontrol = 010.
- op = 100011 (lw) → states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; regwrite = 1 and memtoreg = 1 only in cycle 5; memwrite never 1.
- op = 101011 (sw) → memwrite = 1 and iord = 1 exactly in cycle 4; regwrite never 1.
- op = 000000 with funct 100010, then 101010 → alucontrol = 110 in EXECUTE, then 111; regwrite = 1 and regdst = 1 in ALUWB.
- op = 000100 (beq), zero = 0 in BRANCH → pcen = 0. Repeat with zero = 1 → pcen = 1, pcsrc = 01, alucontrol = 110. Latency 3 cycles in both cases.
- Assert reset during MEMWR of a sw → memwrite drops within the same cycle (asynchronous); next state after release = FETCH. Separately, op = 111111 → DECODE then FETCH with no regwrite or memwrite.
